// File: rtl/eth_frame_sched.sv
// -----------------------------------------------------------------------------
// eth_frame_sched
//   Acquisition-to-Ethernet frame scheduler. Sits directly upstream of
//   eth_session and is the only writer of its byte-write port. On a hardware
//   trigger edge or a software trigger command it emits one frame:
//     header byte, sequence byte, cur_len ADC samples [, checksum trailer]
//   The FIFO full flag is honoured. Header, sequence and trailer bytes stall
//   while full. Samples that arrive while full are dropped and flagged in the
//   sticky o_overrun.
//
//   Optional feature macro: TRAILER_EN
//     When defined, an 8-bit modulo sum of the written samples follows the
//     last sample. When undefined, a frame is 2 + cur_len bytes.
// -----------------------------------------------------------------------------
module eth_frame_sched #(
  parameter int unsigned          DATA_W   = 8,
  parameter int unsigned          LEN_W    = 13,
  parameter int unsigned          DEF_LEN  = 10,
  parameter logic [DATA_W-1:0]    HDR_BYTE = 8'hA5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_trig,
  input  logic [DATA_W-1:0] i_adc_data,
  input  logic              i_adc_valid,
  input  logic              i_cmd_come,
  input  logic [7:0]        i_cmd,
  input  logic [15:0]       i_param,
  input  logic              i_full,
  output logic [DATA_W-1:0] o_data,
  output logic              o_wr,
  output logic              o_busy,
  output logic [15:0]       o_frame_cnt,
  output logic              o_overrun
);

  // Command codes decoded by eth_session
  localparam logic [7:0] CMD_SET_LEN = 8'h01;
  localparam logic [7:0] CMD_SW_TRIG = 8'h02;
  localparam logic [7:0] CMD_CLR_OVR = 8'h03;

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_RST = LEN_W'(DEF_LEN);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    SEQ,
    DATA,
`ifdef TRAILER_EN
    TRL,
`endif
    DONE
  } state_t;

  state_t            state;
  logic              trig_q;
  logic [LEN_W-1:0]  len_reg;
  logic [LEN_W-1:0]  cur_len;
  logic [LEN_W-1:0]  sample_cnt;
`ifdef TRAILER_EN
  logic [DATA_W-1:0] sum;
`endif

  logic              sw_trig;
  logic              start;
  logic [LEN_W-1:0]  len_cmd_val;
  logic              len_cmd_ok;
  logic              ovr_clr;
  logic              last_sample;

  // Parameter bits above the length field carry no meaning for this block
  logic              unused_param_hi;
  assign unused_param_hi = ^i_param[15:LEN_W];

  // Command decode: each strobe carries exactly one command
  assign sw_trig     = i_cmd_come && (i_cmd == CMD_SW_TRIG);
  assign len_cmd_val = i_param[LEN_W-1:0];
  assign len_cmd_ok  = i_cmd_come && (i_cmd == CMD_SET_LEN) && (len_cmd_val != '0);
  assign ovr_clr     = i_cmd_come && (i_cmd == CMD_CLR_OVR);

  // Rising edge of the level trigger, or the software one-shot
  assign start       = (i_trig & ~trig_q) | sw_trig;

  // The sample being accepted this cycle is the final one of the frame
  assign last_sample = (sample_cnt == (cur_len - LEN_ONE));

  // Trigger history; resets high so a trigger held through reset never fires
  // NOTE: every sequential assignment uses <= so all registers update from
  // the same pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      trig_q <= 1'b1;
    end else begin
      trig_q <= i_trig;
    end
  end

  // Programmable frame length; zero is rejected so cur_len never underflows
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      len_reg <= LEN_RST;
    end else if (len_cmd_ok) begin
      len_reg <= len_cmd_val;
    end
  end

  // Frame sequencer with registered byte-write outputs and status
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      o_data      <= '0;
      o_wr        <= 1'b0;
      o_busy      <= 1'b0;
      o_frame_cnt <= '0;
      o_overrun   <= 1'b0;
      cur_len     <= LEN_RST;
      sample_cnt  <= '0;
`ifdef TRAILER_EN
      sum         <= '0;
`endif
    end else begin
      // Write strobe is a single-cycle pulse unless a state re-asserts it
      o_wr <= 1'b0;

      // Clear is placed first so an overrun set later in this block wins
      if (ovr_clr) begin
        o_overrun <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            cur_len    <= len_reg;
            sample_cnt <= '0;
`ifdef TRAILER_EN
            sum        <= '0;
`endif
            o_busy     <= 1'b1;
            state      <= HDR;
          end
        end

        HDR: begin
          if (!i_full) begin
            o_wr   <= 1'b1;
            o_data <= HDR_BYTE;
            state  <= SEQ;
          end
        end

        SEQ: begin
          if (!i_full) begin
            o_wr   <= 1'b1;
            o_data <= o_frame_cnt[DATA_W-1:0];
            state  <= DATA;
          end
        end

        DATA: begin
          if (i_adc_valid) begin
            if (!i_full) begin
              o_wr   <= 1'b1;
              o_data <= i_adc_data;
`ifdef TRAILER_EN
              sum    <= sum + i_adc_data;
`endif
            end else begin
              o_overrun <= 1'b1;
            end
            // A dropped sample still consumes a slot of the frame
            sample_cnt <= sample_cnt + LEN_ONE;
            if (last_sample) begin
`ifdef TRAILER_EN
              state <= TRL;
`else
              state <= DONE;
`endif
            end
          end
        end

`ifdef TRAILER_EN
        TRL: begin
          if (!i_full) begin
            o_wr   <= 1'b1;
            o_data <= sum;
            state  <= DONE;
          end
        end
`endif

        DONE: begin
          o_frame_cnt <= o_frame_cnt + 16'd1;
          o_busy      <= 1'b0;
          state       <= IDLE;
        end

        default: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eth_frame_sched.sv
// -----------------------------------------------------------------------------
// tb_eth_frame_sched
//   Scoreboard bench: every byte the scheduler should write is pushed to
//   exp_q as stimulus is driven; a negedge monitor pops and compares each
//   o_wr byte. Scenario tasks check latency, status and counters inline.
//   Trailer bytes are expected only when TRAILER_EN is defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_eth_frame_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        trig;
  logic [7:0]  adc_data;
  logic        adc_valid;
  logic        cmd_come;
  logic [7:0]  cmd_code;
  logic [15:0] cmd_param;
  logic        full;
  logic [7:0]  o_data;
  logic        o_wr;
  logic        o_busy;
  logic [15:0] o_frame_cnt;
  logic        o_overrun;

  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  exp_q[$];
  int          exp_len  = 10;
  logic [15:0] exp_fcnt = '0;
  bit          exp_ov   = 1'b0;

  eth_frame_sched dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_trig      (trig),
    .i_adc_data  (adc_data),
    .i_adc_valid (adc_valid),
    .i_cmd_come  (cmd_come),
    .i_cmd       (cmd_code),
    .i_param     (cmd_param),
    .i_full      (full),
    .o_data      (o_data),
    .o_wr        (o_wr),
    .o_busy      (o_busy),
    .o_frame_cnt (o_frame_cnt),
    .o_overrun   (o_overrun)
  );

  always #5 clk = ~clk;

  // Byte monitor: every write must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n === 1'b1 && o_wr !== 1'b0) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL byte_unexpected: got wr=%b data=%02h, required no write", o_wr, o_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (o_wr !== 1'b1 || o_data !== e) begin
          n_err++;
          $display("FAIL byte_data: got wr=%b data=%02h, required %02h", o_wr, o_data, e);
        end
      end
    end
  end

  // Hard stop in case some wait escapes its own bound
  initial begin
    #500_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete frame. Length comes from the model's exp_len at start.
  task automatic do_frame(input bit sw, input int stall, input int base, input int step,
                          input int drop_a, input int drop_b, input int cmd_idx,
                          input logic [7:0] cmd, input logic [15:0] param,
                          input bit retrig, input bit gaps);
    int         n;
    int         lat;
    bit         seen;
    logic [7:0] sum;
    logic [7:0] smp;
    n   = exp_len;
    sum = '0;
    exp_q.push_back(8'hA5);
    exp_q.push_back(exp_fcnt[7:0]);
    if (!sw) begin
      trig = 1'b0;
      tick();
      trig = 1'b1;
    end else begin
      cmd_come  = 1'b1;
      cmd_code  = 8'h02;
      cmd_param = '0;
    end
    if (stall > 0) full = 1'b1;
    tick();                       // start sampled here (E0)
    cmd_come = 1'b0;
    lat  = 0;
    seen = 1'b0;
    for (int k = 0; k < stall + 20 && !seen; k++) begin
      if (lat >= stall) full = 1'b0;
      tick();
      lat++;
      if (o_wr === 1'b1) seen = 1'b1;
    end
    n_vec++;
    if (!seen || lat != stall + 1) begin
      n_err++;
      $display("FAIL hdr_latency: got %0d cycles (seen=%0b), required %0d", lat, seen, stall + 1);
      exp_q.delete();
      full = 1'b0;
      trig = 1'b0;
      return;
    end
    n_vec++;
    if (o_busy !== 1'b1) begin
      n_err++;
      $display("FAIL busy_in_frame: got %b, required 1", o_busy);
    end
    tick();
    n_vec++;
    if (o_wr !== 1'b1) begin
      n_err++;
      $display("FAIL seq_latency: got wr=%b one cycle after header, required 1", o_wr);
    end
    trig = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (gaps && (i % 3 == 1)) begin
        adc_valid = 1'b0;
        full      = 1'b0;
        tick();
      end
      smp       = 8'(base + step * i);
      adc_valid = 1'b1;
      adc_data  = smp;
      full      = (i == drop_a) || (i == drop_b);
      if (retrig && i == 2) trig = 1'b1;
      if (i == cmd_idx) begin
        cmd_come  = 1'b1;
        cmd_code  = cmd;
        cmd_param = param;
        if (cmd == 8'h01 && param[12:0] != '0) exp_len = int'(param[12:0]);
        if (cmd == 8'h03) exp_ov = 1'b0;
      end
      if (full) begin
        exp_ov = 1'b1;
      end else begin
        exp_q.push_back(smp);
        sum = sum + smp;
      end
      tick();
      cmd_come = 1'b0;
    end
    adc_valid = 1'b0;
    full      = 1'b0;
    trig      = 1'b0;
`ifdef TRAILER_EN
    exp_q.push_back(sum);
`endif
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick();
      if (o_busy === 1'b0) seen = 1'b1;
    end
    exp_fcnt++;
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL busy_release: got busy=%b after 20 cycles, required 0", o_busy);
    end
    n_vec++;
    if (o_frame_cnt !== exp_fcnt) begin
      n_err++;
      $display("FAIL frame_cnt: got %0d, required %0d", o_frame_cnt, exp_fcnt);
    end
    n_vec++;
    if (o_overrun !== exp_ov) begin
      n_err++;
      $display("FAIL overrun_after_frame: got %b, required %b", o_overrun, exp_ov);
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL frame_bytes: got %0d bytes short, required 0", exp_q.size());
      exp_q.delete();
    end
    // Idle window: any queued or spurious frame shows up as an unexpected write
    repeat (4) tick();
  endtask

  // Command issued while idle, followed by a status check
  task automatic idle_cmd(input logic [7:0] cmd, input logic [15:0] param);
    cmd_come  = 1'b1;
    cmd_code  = cmd;
    cmd_param = param;
    if (cmd == 8'h01 && param[12:0] != '0) exp_len = int'(param[12:0]);
    if (cmd == 8'h03) exp_ov = 1'b0;
    tick();
    cmd_come = 1'b0;
    repeat (2) tick();
    n_vec++;
    if (o_overrun !== exp_ov || o_busy !== 1'b0) begin
      n_err++;
      $display("FAIL idle_cmd_%02h: got overrun=%b busy=%b, required overrun=%b busy=0",
               cmd, o_overrun, o_busy, exp_ov);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    trig  = 1'b1;
    repeat (3) tick();
    n_vec++;
    if (o_data !== 8'h00 || o_wr !== 1'b0 || o_busy !== 1'b0 ||
        o_frame_cnt !== 16'h0 || o_overrun !== 1'b0) begin
      n_err++;
      $display("FAIL reset_values: got data=%02h wr=%b busy=%b cnt=%0d ovr=%b, required all 0",
               o_data, o_wr, o_busy, o_frame_cnt, o_overrun);
    end
    rst_n = 1'b1;
    repeat (6) tick();
    n_vec++;
    if (o_busy !== 1'b0 || o_frame_cnt !== 16'h0) begin
      n_err++;
      $display("FAIL trig_held_at_reset: got busy=%b cnt=%0d, required busy=0 cnt=0",
               o_busy, o_frame_cnt);
    end
  endtask

  task automatic test_basic();
    do_frame(1'b0, 0, 1, 1, -1, -1, -1, 8'h00, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic test_hdr_stall();
    do_frame(1'b0, 5, 8'h40, 1, -1, -1, -1, 8'h00, 16'h0, 1'b0, 1'b0);
  endtask

  // Two drops; an overrun clear lands on the second drop, so the set must win
  task automatic test_drop();
    do_frame(1'b0, 0, 8'h20, 3, 3, 7, 7, 8'h03, 16'h0, 1'b0, 1'b1);
  endtask

  task automatic test_ovr_clear();
    idle_cmd(8'h03, 16'h0);
  endtask

  task automatic test_len_change();
    do_frame(1'b0, 0, 8'h80, 5, -1, -1, 4, 8'h01, 16'd3, 1'b0, 1'b0);
    do_frame(1'b0, 0, 8'hF0, 7, -1, -1, -1, 8'h00, 16'h0, 1'b0, 1'b0);
    idle_cmd(8'h01, 16'h0000);
    idle_cmd(8'h01, 16'h2000);
    idle_cmd(8'h7E, 16'h0005);
    do_frame(1'b0, 0, 8'h11, 2, -1, -1, -1, 8'h00, 16'h0, 1'b0, 1'b0);
    idle_cmd(8'h01, 16'hE001);
    do_frame(1'b0, 0, 8'hC3, 1, -1, -1, -1, 8'h00, 16'h0, 1'b0, 1'b0);
    idle_cmd(8'h01, 16'd10);
  endtask

  task automatic test_sw_trig();
    do_frame(1'b1, 0, 8'h60, 9, -1, -1, -1, 8'h00, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic test_busy_ignore();
    do_frame(1'b0, 0, 8'h05, 11, -1, -1, 1, 8'h02, 16'h0, 1'b1, 1'b0);
  endtask

  task automatic test_trailer_frame();
    idle_cmd(8'h01, 16'd4);
    do_frame(1'b0, 0, 10, 10, -1, -1, -1, 8'h00, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    exp_q.push_back(8'hA5);
    exp_q.push_back(exp_fcnt[7:0]);
    trig = 1'b0;
    tick();
    trig = 1'b1;
    repeat (3) tick();
    adc_valid = 1'b1;
    adc_data  = 8'h55;
    exp_q.push_back(8'h55);
    tick();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    adc_valid = 1'b0;
    trig = 1'b0;
    #1;
    exp_q.delete();
    n_vec++;
    if (o_data !== 8'h00 || o_wr !== 1'b0 || o_busy !== 1'b0 ||
        o_frame_cnt !== 16'h0 || o_overrun !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_frame: got data=%02h wr=%b busy=%b cnt=%0d ovr=%b, required all 0",
               o_data, o_wr, o_busy, o_frame_cnt, o_overrun);
    end
    exp_len  = 10;
    exp_fcnt = '0;
    exp_ov   = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    // Length must be back at its default and the sequence restarted at 00
    do_frame(1'b0, 0, 8'hA0, 1, -1, -1, -1, 8'h00, 16'h0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n     = 1'b0;
    trig      = 1'b1;
    adc_data  = '0;
    adc_valid = 1'b0;
    cmd_come  = 1'b0;
    cmd_code  = '0;
    cmd_param = '0;
    full      = 1'b0;
    test_reset();
    test_basic();
    test_hdr_stall();
    test_drop();
    test_ovr_clear();
    test_len_change();
    test_sw_trig();
    test_busy_ignore();
    test_trailer_frame();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
